// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: direction-counter
// encodings and the branch target buffer entry layout.
package bp_pkg;

  // Widths of the stored tag and target fields of a table entry.
  localparam int BP_ADDR_W = 32;
  localparam int BP_TAG_W  = 8;

  // 2-bit saturating direction counter encodings.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Counter value after reset/clear, and value given to a newly allocated entry.
  localparam logic [1:0] CTR_RST   = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
    logic [1:0]           ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_stat_ctr.sv
// 32-bit event counter that saturates at all-ones; cleared only by reset.
module bp_stat_ctr
  import bp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: step on enable, hold once saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup in IF is combinational from the registered table; training and
// misprediction detection happen in EX. Lookup never sees a same-cycle update.
// Optional statistics counters are built when BP_STATS_EN is defined;
// otherwise both stat outputs are tied to zero.
// TAG_W and ADDR_W must not exceed the entry field widths in bp_pkg.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = BP_TAG_W,
  parameter int ADDR_W  = BP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              clear_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam bp_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RST};

  // Saturating step of a direction counter toward the resolved outcome.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

  bp_entry_t tbl_q [ENTRIES];
  bp_entry_t tbl_d [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // IF-side lookup: taken only on a tag hit with a counter in a taken state.
  always_comb begin
    lk_hit        = tbl_q[lk_idx].valid && (tbl_q[lk_idx].tag == BP_TAG_W'(lk_tag));
    pred_taken_o  = lk_hit && (tbl_q[lk_idx].ctr inside {CTR_WT, CTR_ST});
    pred_target_o = pred_taken_o ? ADDR_W'(tbl_q[lk_idx].target) : pc_i + ADDR_W'(4);
  end

  // EX-side resolution: a wrong direction, or a right "taken" with a wrong target.
  always_comb begin
    mispredict_o  = upd_valid_i &&
                    ((upd_taken_i != upd_pred_taken_i) ||
                     (upd_taken_i && upd_pred_taken_i && (upd_pred_target_i != upd_target_i)));
    redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + ADDR_W'(4);
  end

  // Table next state: clear wins over training; untaken misses never allocate.
  always_comb begin
    up_hit = tbl_q[up_idx].valid && (tbl_q[up_idx].tag == BP_TAG_W'(up_tag));
    tbl_d  = tbl_q;
    if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_d[i].valid = 1'b0;
        tbl_d[i].ctr   = CTR_RST;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        tbl_d[up_idx].ctr = ctr_step(tbl_q[up_idx].ctr, upd_taken_i);
        if (upd_taken_i) begin
          tbl_d[up_idx].target = BP_ADDR_W'(upd_target_i);
        end
      end else if (upd_taken_i) begin
        tbl_d[up_idx] = '{valid:  1'b1,
                          tag:    BP_TAG_W'(up_tag),
                          target: BP_ADDR_W'(upd_target_i),
                          ctr:    CTR_ALLOC};
      end
    end
  end

  // Table registers; reset drops any update presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= ENTRY_RST;
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

`ifdef BP_STATS_EN
  bp_stat_ctr u_stat_branches (
    .clk   (clk),
    .reset (reset),
    .en_i  (upd_valid_i),
    .cnt_o (stat_branches_o)
  );

  bp_stat_ctr u_stat_mispred (
    .clk   (clk),
    .reset (reset),
    .en_i  (mispredict_o),
    .cnt_o (stat_mispred_o)
  );
`else
  assign stat_branches_o = 32'd0;
  assign stat_mispred_o  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a table-of-records reference model plus
// directed sequences with hand-computed literal expectations.
module tb_branch_predictor;

  localparam int ENT  = 64;
  localparam int IDXB = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        clear_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispred_o;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.ENTRIES(ENT), .TAG_W(8), .ADDR_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_i              (pc_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .clear_i           (clear_i),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o),
    .stat_branches_o   (stat_branches_o),
    .stat_mispred_o    (stat_mispred_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per table slot, counter kept as an integer 0..3.
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  longint      m_br;
  longint      m_mis;
  bit          model_ok = 1'b0;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENT)) % 256;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_mispred();
    if (!upd_valid_i) return 1'b0;
    if (upd_taken_i != upd_pred_taken_i) return 1'b1;
    return upd_taken_i && (upd_pred_target_i != upd_target_i);
  endfunction

  // Model state advance on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENT; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
      end
      m_br = 0; m_mis = 0; model_ok = 1'b1;
    end else if (model_ok) begin
      if (upd_valid_i) begin
        if (m_br  < 64'hFFFF_FFFF) m_br++;
        if (m_mispred() && m_mis < 64'hFFFF_FFFF) m_mis++;
      end
      if (clear_i) begin
        for (int i = 0; i < ENT; i++) begin
          m_valid[i] = 1'b0; m_ctr[i] = 1;
        end
      end else if (upd_valid_i) begin
        int s;
        s = slot_of(upd_pc_i);
        if (m_hit(upd_pc_i)) begin
          if (upd_taken_i) begin
            m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
            m_tgt[s] = upd_target_i;
          end else begin
            m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
          end
        end else if (upd_taken_i) begin
          m_valid[s] = 1'b1; m_tag[s] = tag_of(upd_pc_i);
          m_tgt[s] = upd_target_i; m_ctr[s] = 2;
        end
      end
    end
  end

  // Compare process: every cycle the model is initialised, check all outputs.
  always @(negedge clk) begin
    if (model_ok) begin
      bit          e_pt;
      logic [31:0] e_tg;
      e_pt = m_hit(pc_i) && (m_ctr[slot_of(pc_i)] >= 2);
      e_tg = e_pt ? m_tgt[slot_of(pc_i)] : pc_i + 32'd4;
      chk("m_pred_taken", {31'd0, pred_taken_o}, {31'd0, e_pt});
      chk("m_pred_target", pred_target_o, e_tg);
      chk("m_mispredict", {31'd0, mispredict_o}, {31'd0, m_mispred()});
      if (upd_valid_i)
        chk("m_redirect", redirect_pc_o, upd_taken_i ? upd_target_i : upd_pc_i + 32'd4);
`ifdef BP_STATS_EN
      chk("m_stat_br", stat_branches_o, m_br[31:0]);
      chk("m_stat_mis", stat_mispred_o, m_mis[31:0]);
`else
      chk("m_stat_br", stat_branches_o, 32'd0);
      chk("m_stat_mis", stat_mispred_o, 32'd0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid_i = 1'b0; clear_i = 1'b0; upd_taken_i = 1'b0;
    upd_pc_i = 32'd0; upd_target_i = 32'd0;
    upd_pred_taken_i = 1'b0; upd_pred_target_i = 32'd0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg);
    upd_valid_i = 1'b1; upd_pc_i = pc; upd_taken_i = tk; upd_target_i = tg;
    upd_pred_taken_i = ptk; upd_pred_target_i = ptg;
  endtask

  logic [31:0] pcs [8];

  initial begin
    pcs[0] = 32'h0040_0010; pcs[1] = 32'h0040_0110; pcs[2] = 32'h0040_0020;
    pcs[3] = 32'h0040_0024; pcs[4] = 32'h0040_1010; pcs[5] = 32'h0040_00FC;
    pcs[6] = 32'hFFFF_FFFC; pcs[7] = 32'h0040_0210;
    idle();
    pc_i  = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Out of reset: not-taken, PC+4
    pc_i = 32'h0040_0010;
    @(negedge clk);
    chk("rst_pred_taken", {31'd0, pred_taken_o}, 32'd0);
    chk("rst_pred_target", pred_target_o, 32'h0040_0014);
    chk("rst_mispredict", {31'd0, mispredict_o}, 32'd0);
    cyc();

    // First taken resolution: mispredict, same-cycle lookup still old
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    @(negedge clk);
    chk("alloc_mispredict", {31'd0, mispredict_o}, 32'd1);
    chk("alloc_redirect", redirect_pc_o, 32'h0040_0100);
    chk("same_cycle_old", {31'd0, pred_taken_o}, 32'd0);
    cyc();

    // Now predicted taken; train not-taken (ctr 10 -> 01)
    upd(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    @(negedge clk);
    chk("learned_taken", {31'd0, pred_taken_o}, 32'd1);
    chk("learned_target", pred_target_o, 32'h0040_0100);
    chk("nt_redirect", redirect_pc_o, 32'h0040_0014);
    cyc();

    // ctr 01 -> 00
    upd(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0, 32'h0040_0014);
    @(negedge clk);
    chk("wnt_pred", {31'd0, pred_taken_o}, 32'd0);
    chk("nt_ok_no_mis", {31'd0, mispredict_o}, 32'd0);
    cyc();

    // One taken: ctr 00 -> 01, still not-taken
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    cyc();
    idle();
    @(negedge clk);
    chk("after_one_taken", {31'd0, pred_taken_o}, 32'd0);
    chk("after_one_taken_tgt", pred_target_o, 32'h0040_0014);
    cyc();

    // Aliasing: same index, tag 0x01 evicts tag 0x00
    upd(32'h0040_0110, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0114);
    cyc();
    idle();
    @(negedge clk);
    chk("alias_evicted", pred_target_o, 32'h0040_0014);
    cyc();
    pc_i = 32'h0040_0110;
    @(negedge clk);
    chk("alias_new_taken", {31'd0, pred_taken_o}, 32'd1);
    chk("alias_new_target", pred_target_o, 32'h0040_0200);
    cyc();

    // Right direction, wrong target
    upd(32'h0040_0110, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200);
    @(negedge clk);
    chk("tgt_mispredict", {31'd0, mispredict_o}, 32'd1);
    chk("tgt_redirect", redirect_pc_o, 32'h0040_0300);
    cyc();
    idle();
    @(negedge clk);
    chk("tgt_retrained", pred_target_o, 32'h0040_0300);
    cyc();

    // Clear with a concurrent update: update discarded, mispredict still reported
    clear_i = 1'b1;
    upd(32'h0040_0500, 1'b1, 32'h0040_0600, 1'b0, 32'h0040_0504);
    @(negedge clk);
    chk("clear_mispredict", {31'd0, mispredict_o}, 32'd1);
    cyc();
    idle();
    pc_i = 32'h0040_0500;
    @(negedge clk);
    chk("clear_upd_dropped", pred_target_o, 32'h0040_0504);
    cyc();
    pc_i = 32'h0040_0110;
    @(negedge clk);
    chk("clear_empty", {31'd0, pred_taken_o}, 32'd0);
    cyc();

    // Address wrap at the top of memory, last index, tag 0xFF
    pc_i = 32'hFFFF_FFFC;
    upd(32'hFFFF_FFFC, 1'b0, 32'h0000_1000, 1'b0, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_pred_target", pred_target_o, 32'h0000_0000);
    chk("wrap_redirect", redirect_pc_o, 32'h0000_0000);
    cyc();
    upd(32'hFFFF_FFFC, 1'b1, 32'h0000_1000, 1'b0, 32'h0000_0000);
    cyc();
    idle();
    @(negedge clk);
    chk("jump_learned", pred_target_o, 32'h0000_1000);
    cyc();

    // Mixed traffic checked by the model
    for (int n = 0; n < 300; n++) begin
      pc_i = pcs[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) != 0) begin
        upd(pcs[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
            32'h0040_0000 + 32'($urandom_range(0, 3) * 256),
            1'($urandom_range(0, 1)),
            32'h0040_0000 + 32'($urandom_range(0, 3) * 256));
      end else begin
        idle();
      end
      clear_i = ($urandom_range(0, 31) == 0);
      cyc();
    end

    // Reset mid-stream drops the pending update
    reset = 1'b1;
    upd(32'h0040_0800, 1'b1, 32'h0040_0900, 1'b0, 32'h0040_0804);
    cyc();
    reset = 1'b0;
    idle();
    pc_i = 32'h0040_0800;
    @(negedge clk);
    chk("reset_drops_upd", {31'd0, pred_taken_o}, 32'd0);
    chk("reset_stats_br", stat_branches_o, 32'd0);
    cyc();

    // 10 resolutions, 3 of them mispredicted
    for (int n = 0; n < 10; n++) begin
      if (n < 3) upd(32'h0040_0800, 1'b1, 32'h0040_0900, 1'b0, 32'h0040_0804);
      else       upd(32'h0040_0800, 1'b0, 32'h0040_0900, 1'b0, 32'h0040_0804);
      cyc();
    end
    idle();
    @(negedge clk);
`ifdef BP_STATS_EN
    chk("stat_branches", stat_branches_o, 32'd10);
    chk("stat_mispred", stat_mispred_o, 32'd3);
`else
    chk("stat_branches", stat_branches_o, 32'd0);
    chk("stat_mispred", stat_mispred_o, 32'd0);
`endif
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the five-stage MIPS pipeline.
- Predicts next PC in IF from the current PC.
- Is trained in EX, where branches resolve, and flags mispredictions so the hazard logic flushes IF/ID and ID/EX.
- Replaces the fixed "always PC+4, flush on taken" policy with a learned one.

## Interface
- ENTRIES, 64, number of table entries; power of 2, ≥2; IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry; IDX_W+TAG_W+2 ≤ ADDR_W.
- ADDR_W, 32, PC width.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pc_i  in  ADDR_W  IF-stage PC to predict.
- pred_taken_o  out  1  predicted taken.
- pred_target_o  out  ADDR_W  predicted next PC.
- clear_i  in  1  invalidate whole table (context switch / self-modifying code).
- upd_valid_i  in  1  EX holds a resolved branch or jump this cycle.
- upd_pc_i  in  ADDR_W  PC of the resolved instruction.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_pred_taken_i  in  1  prediction made in IF, carried down the pipe.
- upd_pred_target_i  in  ADDR_W  predicted target, carried down the pipe.
- mispredict_o  out  1  EX outcome disagrees with the IF prediction.
- redirect_pc_o  out  ADDR_W  correct next PC when mispredict_o=1.
- stat_branches_o  out  32  resolved-branch count.
- stat_mispred_o  out  32  misprediction count.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry = {valid, tag, target[ADDR_W-1:0], ctr[1:0]}.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational from registered table):
  - hit = valid & tag match.
  - pred_taken_o = hit & ctr[1].
  - pred_target_o = pred_taken_o ? target : pc_i+4.
- Update when upd_valid_i=1:
  - Hit at upd_pc_i: ctr increments (taken) or decrements (not taken), saturating at 11/00; target <= upd_target_i if taken.
  - Miss and taken: allocate/overwrite; valid=1, tag, target, ctr=10.
  - Miss and not taken: no allocation.
- mispredict_o = upd_valid_i & ((upd_taken_i≠upd_pred_taken_i) | (upd_taken_i & upd_pred_taken_i & upd_pred_target_i≠upd_target_i)).
- redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4.
- Jumps are trained as always-taken branches.
- Adders wrap modulo 2^ADDR_W.

## Timing
- Prediction latency 0 cycles: outputs are a combinational function of pc_i and table state.
- Update is visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: lookup sees the pre-update entry; no bypass.
- mispredict_o and redirect_pc_o are combinational in the same cycle as upd_valid_i.
- Reset: all valid=0, all ctr=01, targets/tags=0, stat counters=0. Out of reset: pred_taken_o=0, pred_target_o=pc_i+4, mispredict_o=0.
- clear_i: valid=0 and ctr=01 for all entries next cycle.
  - Has priority over a same-cycle update; that update is discarded.
  - mispredict_o is still reported.
  - Stat counters are not affected.
- reset has priority over clear_i and updates; reset mid-stream drops any pending update.

## Configuration
- BP_STATS_EN defined:
  - stat_branches_o increments on each upd_valid_i.
  - stat_mispred_o increments on each mispredict_o.
  - Both saturate at 0xFFFF_FFFF, cleared only by reset.
- Not defined: both stat outputs tied to 0, no counter flops synthesised.

## Structure
- Package bp_pkg holds:
  - Counter encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
  - Reset counter value CTR_RST=CTR_WNT and allocation value CTR_ALLOC=CTR_WT.
  - bp_entry_t struct.
- One sub-module, bp_stat_ctr: 32-bit saturating enable counter with sync reset, instantiated twice under BP_STATS_EN.

## Test plan
- Reset, then pc_i=0x0040_0010 → pred_taken_o=0, pred_target_o=0x0040_0014.
- Update pc=0x0040_0010, taken, target 0x0040_0100, pred_taken=0 → mispredict_o=1, redirect 0x0040_0100. Next cycle lookup → pred_taken_o=1, target 0x0040_0100.
- Same PC resolved not-taken twice: ctr 10→01→00; lookup → pred_taken_o=0. One taken → ctr 01, still predicts not-taken.
- Aliasing, ENTRIES=64, pc 0x0040_0010 vs 0x0040_0110 (same index, tags 0x00/0x01): taken update of the second evicts the first; lookup of the first → miss, PC+4.
- Same-cycle lookup and update of the same index → old prediction returned, new one next cycle. clear_i with update → table empty next cycle.
- BP_STATS_EN: 10 updates with 3 mispredicts → stat_branches_o=10, stat_mispred_o=3. Without macro → both 0.
